// File: rtl/bp_table_ctrl_pkg.sv
// Shared constants for the branch history table controller:
// counter init value, saturation limits, FSM state encoding and
// the 2-bit saturating counter update rule.
package bp_table_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } bp_state_e;

    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MIN  = 2'b00;
    localparam logic [1:0] CTR_MAX  = 2'b11;

    // Saturating 2-bit counter step: taken counts up to CTR_MAX,
    // not-taken counts down to CTR_MIN.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) r = ctr + 2'd1;
        end else begin
            if (ctr != CTR_MIN) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_counter_ram.sv
// Single-port 2**INDEX_W x 2-bit counter RAM with synchronous read.
// Read data appears the cycle after an en & !we strobe and holds otherwise.
module bp_counter_ram #(
    parameter int unsigned INDEX_W = 8
) (
    input  logic               clk_in,
    input  logic               en,
    input  logic               we,
    input  logic [INDEX_W-1:0] idx,
    input  logic [1:0]         wdata,
    output logic [1:0]         rdata
);

    logic [1:0] mem [2**INDEX_W];

    // One access per cycle: write, or registered read.
    always_ff @(posedge clk_in) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch history table controller: arbitrates the single-port counter
// table between fetch lookups and buffered commit updates (read-modify-
// write), and sweeps the table to weakly-not-taken after reset.
// Optional build macro BP_CTRL_PERF_EN adds perf_lookups / perf_stalls.
module bp_table_ctrl #(
    parameter int unsigned INDEX_W    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               lk_valid,
    input  logic [31:0]        lk_pc,
    output logic               lk_ready,
    output logic               pred_valid,
    output logic               pred_taken,
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic               upd_taken,
    output logic               upd_ready,
    output logic               tbl_en,
    output logic               tbl_we,
    output logic [INDEX_W-1:0] tbl_idx,
    output logic [1:0]         tbl_wdata,
    input  logic [1:0]         tbl_rdata
`ifdef BP_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_stalls
`endif
);

    import bp_table_ctrl_pkg::*;

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [INDEX_W-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);

    bp_state_e          state_q, state_d;
    logic [INDEX_W-1:0] sweep_q, sweep_d;

    logic [INDEX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic               fifo_tkn [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [INDEX_W-1:0] rmw_idx;
    logic               rmw_tkn;
    logic [1:0]         rmw_ctr;
    logic               pred_q;

    logic               active;
    logic               fifo_full, fifo_empty;
    logic               push, pop, lk_accept;
    logic [INDEX_W-1:0] lk_idx, upd_idx;
    logic               unused_pc_bits;

    assign lk_idx  = lk_pc[INDEX_W+1:2];
    assign upd_idx = upd_pc[INDEX_W+1:2];
    assign unused_pc_bits = ^{lk_pc[31:INDEX_W+2], lk_pc[1:0],
                              upd_pc[31:INDEX_W+2], upd_pc[1:0]};

    // Reset and rdy_in both suppress every handshake and table strobe,
    // so an RMW caught by reset never reaches the table.
    assign active     = rdy_in & ~rst_in;
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    assign lk_ready   = active & (state_q == ST_IDLE) & ~fifo_full;
    assign upd_ready  = active & (state_q != ST_INIT) & ~fifo_full;
    assign push       = upd_valid & upd_ready;

    assign pred_valid = pred_q & active;
    assign pred_taken = pred_valid & tbl_rdata[1];

    // Next-state and table strobe selection.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        pop       = 1'b0;
        lk_accept = 1'b0;
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_idx   = '0;
        tbl_wdata = '0;
        if (active) begin
            unique case (state_q)
                ST_INIT: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_idx   = sweep_q;
                    tbl_wdata = CTR_INIT;
                    sweep_d   = sweep_q + INDEX_W'(1);
                    if (sweep_q == IDX_LAST) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (fifo_full) begin
                        pop     = 1'b1;
                        tbl_en  = 1'b1;
                        tbl_idx = fifo_idx[rd_ptr];
                        state_d = ST_UPD_RD;
                    end else if (lk_valid) begin
                        lk_accept = 1'b1;
                        tbl_en    = 1'b1;
                        tbl_idx   = lk_idx;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        tbl_en  = 1'b1;
                        tbl_idx = fifo_idx[rd_ptr];
                        state_d = ST_UPD_RD;
                    end
                end
                ST_UPD_RD: begin
                    state_d = ST_UPD_WR;
                end
                ST_UPD_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_idx   = rmw_idx;
                    tbl_wdata = ctr_next(rmw_ctr, rmw_tkn);
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Control state: FSM, sweep pointer, FIFO pointers/count, prediction flag.
    // pred_q follows lk_accept even while frozen so a prediction is never
    // re-presented on a later cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pred_q  <= 1'b0;
        end else begin
            pred_q <= lk_accept;
            if (rdy_in) begin
                state_q <= state_d;
                sweep_q <= sweep_d;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage and RMW operand capture (data path, no reset needed).
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_idx[wr_ptr] <= upd_idx;
            fifo_tkn[wr_ptr] <= upd_taken;
        end
        if (pop) begin
            rmw_idx <= fifo_idx[rd_ptr];
            rmw_tkn <= fifo_tkn[rd_ptr];
        end
        if (active && state_q == ST_UPD_RD) begin
            rmw_ctr <= tbl_rdata;
        end
    end

`ifdef BP_CTRL_PERF_EN
    // Accepted-lookup and lookup-stall counters, wrapping at 2**32.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_lookups <= '0;
            perf_stalls  <= '0;
        end else if (rdy_in) begin
            if (lk_accept) perf_lookups <= perf_lookups + 32'd1;
            if (lk_valid && !lk_ready && state_q != ST_INIT) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
